frame_buffer: RTL and testbench
===============================

Name: frame_buffer

Overview:
- Consumes the 12-bit fast words (fData/fVal) and the optional slow word (sData/sVal) from the byte-to-word writer stage.
- Assembles one 17-word page per packet: 16 fast words plus 1 slow slot.
- Holds pages in a triple buffer so the M16 frame generator always reads a complete, coherent page.
- Bursts a page out serially on request.

Parameters:
- FWORDS, 16, fast words per page (slot 16 is the slow word)
- SLOW_TO, 2000, clocks to wait for sVal after the last fast word before committing with slow slot = 0
- CNTW, 8, width of the saturating overflow/stale counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- fData  in  12  fast word
- fVal  in  1  fast word valid, one-cycle pulse
- sData  in  12  slow word
- sVal  in  1  slow word valid, one-cycle pulse
- rdStart  in  1  page read request pulse from frame generator
- oData  out  12  serial page word
- oVal  out  1  oData valid
- oLast  out  1  high with word 16
- oStale  out  1  high for whole burst if the page was already read before
- ovfCnt  out  CNTW  unread pages overwritten, saturating
- staleCnt  out  CNTW  stale bursts served, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state:
  - all outputs 0
  - all three pages zeroed
  - page indices write=0, ready=1, read=2
  - fresh=0, write FSM in FILL, wrIdx=0, burst idle
- Write FSM, state FILL:
  - fVal writes fData to write page slot wrIdx; wrIdx++.
  - On the write with wrIdx==FWORDS-1: wrIdx<=0, timeout counter<=0, go to WAIT_SLOW.
  - sVal in FILL is ignored.
- Write FSM, state WAIT_SLOW (counter increments each cycle):
  - sVal: write sData to slot 16, commit, go to FILL.
  - fVal (sVal absent): slot 16 <= 0, commit, and fData is written to slot 0 of the new write page; wrIdx<=1; go to FILL.
  - sVal and fVal in the same cycle: sData goes to slot 16, commit, fData goes to slot 0 of the new page, wrIdx<=1.
  - Counter reaches SLOW_TO-1 with no sVal/fVal: slot 16 <= 0, commit, go to FILL.
- Commit:
  - swap write<->ready indices; fresh<=1.
  - If fresh was already 1, ovfCnt++ (saturate at all-ones).
  - The new write page is not cleared; stale slots are overwritten as words arrive.
- Read request acceptance:
  - rdStart is accepted only when the burst is idle.
  - rdStart during a burst is ignored (no counter change).
- Accepted rdStart, no commit in the same cycle:
  - fresh=1: swap ready<->read, fresh<=0, oStale=0 for the burst.
  - fresh=0: replay the current read page, oStale=1, staleCnt++ (saturating).
- Accepted rdStart with commit in the same cycle:
  - read<=current write page (the newest); write<=old read page; ready unchanged; fresh<=0.
  - If fresh was 1, ovfCnt++.
  - oStale=0.
- Burst timing:
  - rdStart accepted at cycle N: oVal=1 on cycles N+1..N+17, oData = read page slots 0..16 in order.
  - oLast=1 on cycle N+17 only.
  - oData=0 whenever oVal=0.
  - Next rdStart is acceptable from cycle N+17; a back-to-back burst starts at N+18 with no gap cycle.
- During a burst:
  - The read page is never written, because commits only swap the write and ready pages.
  - Input words keep flowing with zero back-pressure; the block never drops an input word except through ovf page overwrite.
- Reset asserted mid-burst or mid-fill: everything returns to reset state on the next clock edge, and a partial page is discarded.

Test Plan:
- After reset, rdStart pulse -> 17 words of 12'h000, oStale=1, oLast on the 17th, staleCnt=1.
- 16 fVal words 12'h010..12'h01F then sVal 12'h5A2, then rdStart -> oData 12'h010..12'h01F, 12'h5A2, oStale=0, first oVal 1 cycle after rdStart.
- 16 fVal words, no sVal, idle SLOW_TO cycles, rdStart -> slot 16 reads 12'h000; the same after 16 fVal immediately followed by a 17th fVal, which then appears as slot 0 of the next page.
- Three complete packets with no rdStart -> ovfCnt=2; rdStart returns the third packet.
- Commit and rdStart in the same cycle while fresh=1 -> burst carries the newest packet, ovfCnt increments by 1, and a second rdStart gives oStale=1.
- rdStart pulsed mid-burst -> ignored, burst length stays 17; rst high mid-burst -> oVal=0 the next cycle, pages zeroed.

Source files
------------

// File: rtl/frame_buffer_if.sv
// Page-buffer bus: fast/slow word inputs from the word writer, read request
// from the frame generator, serial page output and status counters.
interface frame_buffer_if #(
  parameter int CNTW = 8
);
  logic [11:0]     fData;
  logic            fVal;
  logic [11:0]     sData;
  logic            sVal;
  logic            rdStart;
  logic [11:0]     oData;
  logic            oVal;
  logic            oLast;
  logic            oStale;
  logic [CNTW-1:0] ovfCnt;
  logic [CNTW-1:0] staleCnt;

  modport master (
    output fData, fVal, sData, sVal, rdStart,
    input  oData, oVal, oLast, oStale, ovfCnt, staleCnt
  );

  modport slave (
    input  fData, fVal, sData, sVal, rdStart,
    output oData, oVal, oLast, oStale, ovfCnt, staleCnt
  );
endinterface

// File: rtl/frame_buffer.sv
// Triple-buffered page assembler: 16 fast words plus one slow slot per page.
// A page is committed to the ready slot when its slow word arrives, when the
// next packet starts, or after a timeout; the reader always bursts a whole,
// coherent page.
//
// state     | meaning
// FILL      | writing fast words into slots 0..FWORDS-1 of the write page
// WAIT_SLOW | fast words done, waiting for the slow word or a timeout
module frame_buffer #(
  parameter int FWORDS  = 16,
  parameter int SLOW_TO = 2000,
  parameter int CNTW    = 8
) (
  input logic           clk,
  input logic           rst,
  frame_buffer_if.slave bus
);
  localparam int NSLOT = FWORDS + 1;
  localparam int IW    = $clog2(FWORDS);
  localparam int SW    = $clog2(NSLOT);
  localparam int TW    = $clog2(SLOW_TO);

  typedef enum logic {FILL, WAIT_SLOW} wr_state_t;

  wr_state_t       state, state_nxt;
  logic [11:0]     pages [3][NSLOT];
  logic [1:0]      wr_pg, rdy_pg, rd_pg;
  logic [1:0]      wr_pg_nxt, rdy_pg_nxt, rd_pg_nxt;
  logic            fresh, fresh_nxt;
  logic [IW-1:0]   wr_idx, wr_idx_nxt;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic            commit, rd_acc, ovf_inc, stale_inc, burst_stale;
  logic            fw_en, fw_new_page;
  logic [IW-1:0]   fw_idx;
  logic [1:0]      fw_pg;
  logic            sw_en;
  logic [11:0]     sw_data;
  logic [11:0]     odata;
  logic            oval, olast, ostale;
  logic [SW-1:0]   b_idx;
  logic [CNTW-1:0] ovf_cnt, stale_cnt;

  // Write FSM: decides slot writes and when the write page is committed.
  always_comb begin
    state_nxt   = state;
    wr_idx_nxt  = wr_idx;
    to_cnt_nxt  = to_cnt;
    commit      = 1'b0;
    sw_en       = 1'b0;
    sw_data     = '0;
    fw_en       = 1'b0;
    fw_new_page = 1'b0;
    fw_idx      = wr_idx;
    case (state)
      FILL: begin
        if (bus.fVal) begin
          fw_en = 1'b1;
          if (wr_idx == IW'(FWORDS - 1)) begin
            wr_idx_nxt = '0;
            to_cnt_nxt = '0;
            state_nxt  = WAIT_SLOW;
          end else begin
            wr_idx_nxt = wr_idx + 1'b1;
          end
        end
      end
      WAIT_SLOW: begin
        to_cnt_nxt = to_cnt + 1'b1;
        if (bus.sVal || bus.fVal || to_cnt == TW'(SLOW_TO - 1)) begin
          commit    = 1'b1;
          sw_en     = 1'b1;
          sw_data   = bus.sVal ? bus.sData : 12'h000;
          state_nxt = FILL;
          // A fast word here opens the next packet on the freshly swapped page.
          if (bus.fVal) begin
            fw_en       = 1'b1;
            fw_new_page = 1'b1;
            fw_idx      = '0;
            wr_idx_nxt  = IW'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Page rotation between write, ready and read slots.
  always_comb begin
    rd_acc      = bus.rdStart && (!oval || olast);
    wr_pg_nxt   = wr_pg;
    rdy_pg_nxt  = rdy_pg;
    rd_pg_nxt   = rd_pg;
    fresh_nxt   = fresh;
    ovf_inc     = 1'b0;
    stale_inc   = 1'b0;
    burst_stale = 1'b0;
    if (commit && rd_acc) begin
      // Reader takes the page just completed; ready page becomes obsolete.
      rd_pg_nxt = wr_pg;
      wr_pg_nxt = rd_pg;
      fresh_nxt = 1'b0;
      ovf_inc   = fresh;
    end else if (commit) begin
      wr_pg_nxt  = rdy_pg;
      rdy_pg_nxt = wr_pg;
      fresh_nxt  = 1'b1;
      ovf_inc    = fresh;
    end else if (rd_acc) begin
      if (fresh) begin
        rdy_pg_nxt = rd_pg;
        rd_pg_nxt  = rdy_pg;
        fresh_nxt  = 1'b0;
      end else begin
        burst_stale = 1'b1;
        stale_inc   = 1'b1;
      end
    end
  end

  assign fw_pg = fw_new_page ? wr_pg_nxt : wr_pg;

  // State, index and page-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_idx <= '0;
      to_cnt <= '0;
      wr_pg  <= 2'd0;
      rdy_pg <= 2'd1;
      rd_pg  <= 2'd2;
      fresh  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_idx <= wr_idx_nxt;
      to_cnt <= to_cnt_nxt;
      wr_pg  <= wr_pg_nxt;
      rdy_pg <= rdy_pg_nxt;
      rd_pg  <= rd_pg_nxt;
      fresh  <= fresh_nxt;
    end
  end

  // Page storage; the read page is never a write target.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        for (int s = 0; s < NSLOT; s++) begin
          pages[p][s] <= '0;
        end
      end
    end else begin
      if (fw_en) pages[fw_pg][fw_idx] <= bus.fData;
      if (sw_en) pages[wr_pg][FWORDS] <= sw_data;
    end
  end

  // Serial burst: slot 0 is fetched on acceptance, the rest follow back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata  <= '0;
      oval   <= 1'b0;
      olast  <= 1'b0;
      ostale <= 1'b0;
      b_idx  <= '0;
    end else if (rd_acc) begin
      odata  <= pages[rd_pg_nxt][0];
      oval   <= 1'b1;
      olast  <= 1'b0;
      ostale <= burst_stale;
      b_idx  <= SW'(1);
    end else if (oval && !olast) begin
      odata <= pages[rd_pg][b_idx];
      olast <= (b_idx == SW'(FWORDS));
      b_idx <= b_idx + 1'b1;
    end else begin
      odata  <= '0;
      oval   <= 1'b0;
      olast  <= 1'b0;
      ostale <= 1'b0;
    end
  end

  // Saturating overflow and stale-burst counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt   <= '0;
      stale_cnt <= '0;
    end else begin
      if (ovf_inc && ovf_cnt != '1)     ovf_cnt   <= ovf_cnt + 1'b1;
      if (stale_inc && stale_cnt != '1) stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign bus.oData    = odata;
  assign bus.oVal     = oval;
  assign bus.oLast    = olast;
  assign bus.oStale   = ostale;
  assign bus.ovfCnt   = ovf_cnt;
  assign bus.staleCnt = stale_cnt;
endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: packet vectors from a table, hand-written corner
// sequences, and a scoreboard queue checked by a monitor on every cycle.
module tb_frame_buffer;
  localparam int FWORDS  = 16;
  localparam int SLOW_TO = 2000;
  localparam int CNTW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_buffer_if #(.CNTW(CNTW)) bus ();

  frame_buffer #(.FWORDS(FWORDS), .SLOW_TO(SLOW_TO), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] data;
    bit          last;
    bit          stale;
  } exp_word_t;

  typedef struct {
    logic [11:0] base;
    int          gap;
    bit          do_slow;
    logic [11:0] sval;
    logic [11:0] exp16;
  } vec_t;

  typedef logic [11:0] page_t [17];

  exp_word_t sb[$];
  exp_word_t mon_e;
  int  n_pass  = 0;
  int  n_total = 0;
  bit  in_reset = 1'b1;
  int  exp_ovf;
  int  exp_stale;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every burst word is popped from the scoreboard; idle cycles must be quiet.
  always @(posedge clk) begin
    #1;
    if (!in_reset && !rst) begin
      if (bus.oVal) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL burst_extra: got word %0h expected no word at %0t", bus.oData, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("burst_data", 32'(bus.oData), 32'(mon_e.data));
          chk("burst_last", 32'(bus.oLast), 32'(mon_e.last));
          chk("burst_stale", 32'(bus.oStale), 32'(mon_e.stale));
        end
      end else begin
        chk("idle_data", 32'(bus.oData), 0);
        chk("idle_last", 32'(bus.oLast), 0);
      end
    end
  end

  task automatic cyc(bit fv, logic [11:0] fd, bit sv, logic [11:0] sd, bit rd);
    bus.fVal = fv; bus.fData = fd; bus.sVal = sv; bus.sData = sd; bus.rdStart = rd;
    @(posedge clk);
    #2;
    bus.fVal = 1'b0; bus.fData = '0; bus.sVal = 1'b0; bus.sData = '0; bus.rdStart = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
  endtask

  task automatic send16(logic [11:0] base);
    for (int i = 0; i < FWORDS; i++) cyc(1'b1, base + 12'(i), 1'b0, 12'h0, 1'b0);
  endtask

  task automatic mk_page(input logic [11:0] base, input logic [11:0] s16, output page_t p);
    for (int i = 0; i < FWORDS; i++) p[i] = base + 12'(i);
    p[16] = s16;
  endtask

  task automatic push_page(input page_t p, input bit stale);
    for (int s = 0; s < 17; s++) sb.push_back('{p[s], (s == 16), stale});
  endtask

  task automatic read(input page_t p, input bit stale);
    push_page(p, stale);
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    chk("first_oval", 32'(bus.oVal), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    chk("drain_empty", 32'(sb.size()), 0);
    sb.delete();
    idle(2);
  endtask

  task automatic chk_cnts(string tag);
    chk({tag, "_ovf"}, 32'(bus.ovfCnt), 32'(exp_ovf));
    chk({tag, "_stale"}, 32'(bus.staleCnt), 32'(exp_stale));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [5];
    page_t p;

    vecs[0] = '{12'h010, 0,           1'b1, 12'h5A2, 12'h5A2};
    vecs[1] = '{12'h100, SLOW_TO - 1, 1'b1, 12'h777, 12'h777};
    vecs[2] = '{12'h200, SLOW_TO,     1'b1, 12'h888, 12'h000};
    vecs[3] = '{12'h300, SLOW_TO + 3, 1'b0, 12'h000, 12'h000};
    vecs[4] = '{12'hF00, 0,           1'b1, 12'hFFF, 12'hFFF};

    rst = 1'b1;
    bus.fVal = 1'b0; bus.fData = '0; bus.sVal = 1'b0; bus.sData = '0; bus.rdStart = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    in_reset = 1'b0;
    exp_ovf = 0;
    exp_stale = 0;
    chk("rst_oval", 32'(bus.oVal), 0);
    chk("rst_odata", 32'(bus.oData), 0);
    chk("rst_ostale", 32'(bus.oStale), 0);
    chk_cnts("rst");

    // Read straight after reset: zero page, replayed as stale.
    mk_page(12'h000, 12'h000, p);
    p[0:15] = '{default: 12'h000};
    read(p, 1'b1);
    exp_stale = 1;
    drain();
    chk_cnts("first_read");

    // Table of packets: slow word timing around the timeout boundary.
    for (int v = 0; v < 5; v++) begin
      send16(vecs[v].base);
      idle(vecs[v].gap);
      if (vecs[v].do_slow) cyc(1'b0, 12'h0, 1'b1, vecs[v].sval, 1'b0);
      mk_page(vecs[v].base, vecs[v].exp16, p);
      read(p, 1'b0);
      drain();
      chk_cnts("vec");
    end

    // 17th fast word closes the page and opens the next one; read while filling.
    send16(12'h400);
    cyc(1'b1, 12'h4F0, 1'b0, 12'h0, 1'b0);
    mk_page(12'h400, 12'h000, p);
    push_page(p, 1'b0);
    cyc(1'b1, 12'h4F1, 1'b0, 12'h0, 1'b1);
    chk("first_oval", 32'(bus.oVal), 1);
    for (int i = 2; i < FWORDS; i++) cyc(1'b1, 12'h4F0 + 12'(i), 1'b0, 12'h0, 1'b0);
    cyc(1'b0, 12'h0, 1'b1, 12'h321, 1'b0);
    drain();
    mk_page(12'h4F0, 12'h321, p);
    read(p, 1'b0);
    drain();
    chk_cnts("next_page");

    // Three packets unread: two overwrites, newest is served.
    send16(12'h600); cyc(1'b0, 12'h0, 1'b1, 12'h0A1, 1'b0);
    send16(12'h700); cyc(1'b0, 12'h0, 1'b1, 12'h0A2, 1'b0);
    send16(12'h800); cyc(1'b0, 12'h0, 1'b1, 12'h0A3, 1'b0);
    exp_ovf = 2;
    chk_cnts("three_pkts");
    mk_page(12'h800, 12'h0A3, p);
    read(p, 1'b0);
    drain();

    // Commit and read in the same cycle while a fresh page waits.
    send16(12'h900); cyc(1'b0, 12'h0, 1'b1, 12'h0A4, 1'b0);
    send16(12'hA00);
    mk_page(12'hA00, 12'h0B5, p);
    push_page(p, 1'b0);
    cyc(1'b0, 12'h0, 1'b1, 12'h0B5, 1'b1);
    chk("first_oval", 32'(bus.oVal), 1);
    exp_ovf = 3;
    drain();
    chk_cnts("same_cycle");
    read(p, 1'b1);
    exp_stale = 2;
    drain();
    chk_cnts("replay");

    // rdStart mid-burst is ignored.
    read(p, 1'b1);
    idle(4);
    cyc(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
    exp_stale = 3;
    drain();
    idle(5);
    chk_cnts("mid_burst_rd");

    // Back-to-back: second request on the oLast cycle starts with no gap.
    read(p, 1'b1);
    idle(FWORDS);
    chk("b2b_olast", 32'(bus.oLast), 1);
    read(p, 1'b1);
    exp_stale = 5;
    drain();
    chk_cnts("b2b");

    // Reset mid-burst and mid-fill.
    send16(12'hB00); cyc(1'b0, 12'h0, 1'b1, 12'h0C1, 1'b0);
    mk_page(12'hB00, 12'h0C1, p);
    read(p, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'hD00 + 12'(i), 1'b0, 12'h0, 1'b0);
    in_reset = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_oval", 32'(bus.oVal), 0);
    sb.delete();
    exp_ovf = 0;
    exp_stale = 0;
    chk_cnts("midrst");
    rst = 1'b0;
    #1;
    in_reset = 1'b0;
    mk_page(12'h000, 12'h000, p);
    p[0:15] = '{default: 12'h000};
    read(p, 1'b1);
    exp_stale = 1;
    drain();
    chk_cnts("after_rst");
    send16(12'hE00); cyc(1'b0, 12'h0, 1'b1, 12'h0E1, 1'b0);
    mk_page(12'hE00, 12'h0E1, p);
    read(p, 1'b0);
    drain();
    chk_cnts("after_rst_pkt");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
